param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 149 ++++++++++++++
 tb/tb_param_sync_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo
// Description : Single-clock parameterised FIFO built on a DEPTH x WIDTH
//               register array. Read/write pointers carry one extra wrap bit
//               so full and empty are distinguished without a separate
//               counter. Provides occupancy, almost-full/almost-empty flags
//               and single-cycle overflow/underflow error pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      : data word width in bits (>= 1)
//   DEPTH      : number of entries, power of two, >= 4
//   AF_THRESH  : almost_full when free entries <= AF_THRESH
//   AE_THRESH  : almost_empty when occupancy   <= AE_THRESH
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   wr_en        in   write request
//   fifo_in      in   write data [WIDTH-1:0]
//   rd_en        in   read request / pop
//   fifo_out     out  read data [WIDTH-1:0]
//   out_valid    out  fifo_out holds valid data
//   full, empty, almost_full, almost_empty   out  status flags
//   count        out  occupancy 0..DEPTH [$clog2(DEPTH):0]
//   overflow     out  pulse: write attempted while full (previous cycle)
//   underflow    out  pulse: read attempted while empty (previous cycle)
// Build option
//   PARAM_FIFO_FWFT_EN : when defined, first-word-fall-through output
//                        (fifo_out shows the head word, out_valid = !empty).
//                        When undefined, registered output with one-cycle
//                        read latency.
// ============================================================================
module param_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 4,
    parameter int AE_THRESH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       fifo_in,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       fifo_out,
    output logic                   out_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] c_AF_LEVEL = PW'(DEPTH - AF_THRESH);
    localparam logic [PW-1:0] c_AE_LEVEL = PW'(AE_THRESH);

    // Storage and pointers
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [PW-1:0]    w_count;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Status derived purely from registered pointers.
    // Same low bits with differing wrap bits means the writer is exactly one
    // lap ahead of the reader.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_count  = r_wr_ptr - r_rd_ptr;

    // A write is refused when full even if a read happens in the same cycle.
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    assign empty        = w_empty;
    assign full         = w_full;
    assign count        = w_count;
    assign almost_full  = (w_count >= c_AF_LEVEL);
    assign almost_empty = (w_count <= c_AE_LEVEL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Pointer and error-pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    // Array is not reset: stale contents are unreachable once the pointers
    // are cleared. Writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr[AW-1:0]] <= fifo_in;
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    // Head word is presented continuously; rd_en acknowledges it.
    assign fifo_out  = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid = !w_empty;
`else
    logic [WIDTH-1:0] r_fifo_out;
    logic             r_out_valid;

    // Registered output: data appears the cycle after an accepted read and
    // is held afterwards; out_valid marks only that one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_fifo_out <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    assign fifo_out  = r_fifo_out;
    assign out_valid = r_out_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_sync_fifo
// Description : Scoreboard bench for param_sync_fifo (WIDTH=8, DEPTH=16,
//               thresholds 4). Stimulus pushes hand-computed expected read
//               data into a queue; an independent monitor pops and compares
//               whenever the FIFO presents a word. Status flags are checked
//               directly after each stimulus cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] fifo_in;
    logic             rd_en;
    logic [WIDTH-1:0] fifo_out;
    logic             out_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    param_sync_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_THRESH(4),
        .AE_THRESH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .fifo_in     (fifo_in),
        .rd_en       (rd_en),
        .fifo_out    (fifo_out),
        .out_valid   (out_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then return #1 after the capturing edge.
    task automatic tick(input logic w, input logic [WIDTH-1:0] d, input logic r);
        wr_en   = w;
        fifo_in = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Read request that is expected to return word d.
    task automatic rd_exp(input logic [WIDTH-1:0] d);
        exp_q.push_back(d);
        tick(1'b0, '0, 1'b1);
    endtask

    // Monitor: pops one expected word per presented/consumed output.
    always @(negedge clk) begin
        logic present;
`ifdef PARAM_FIFO_FWFT_EN
        present = out_valid && rd_en && !rst;
`else
        present = out_valid && !rst;
`endif
        if (present) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got data 0x%0h expected no output at %0t", fifo_out, $time);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("sb_data", {24'd0, fifo_out}, {24'd0, e});
            end
        end
    end

    initial begin
        int exp_cnt;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        fifo_in = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        check("rst_valid", out_valid, 0);
`ifndef PARAM_FIFO_FWFT_EN
        check("rst_out", fifo_out, 0);
`endif
        // Inputs asserted under reset are ignored
        tick(1'b1, 8'hFF, 1'b0);
        check("rst_ignore_wr", count, 0);
        rst = 1'b0;
        tick(1'b0, '0, 1'b0);

        // Underflow on empty read
        tick(1'b0, '0, 1'b1);
        check("udf_pulse", underflow, 1);
        check("udf_count", count, 0);
        check("udf_valid", out_valid, 0);
        tick(1'b0, '0, 1'b0);
        check("udf_clear", underflow, 0);

`ifndef PARAM_FIFO_FWFT_EN
        // Basic write x3, read x3
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        tick(1'b1, 8'h33, 1'b0);
        check("b_count3", count, 3);
        check("b_empty0", empty, 0);
        rd_exp(8'h11);
        check("b_valid1", out_valid, 1);
        check("b_count2", count, 2);
        rd_exp(8'h22);
        rd_exp(8'h33);
        check("b_count0", count, 0);
        check("b_empty1", empty, 1);
        tick(1'b0, '0, 1'b0);
        check("b_valid0", out_valid, 0);
        check("b_hold", fifo_out, 8'h33);

        // Fill to full, overflow, write blocked while full with a read
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            check("f_count", count, i + 1);
            check("f_af", almost_full, (i + 1 >= 12) ? 1 : 0);
        end
        check("f_full", full, 1);
        tick(1'b1, 8'hEE, 1'b0);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 16);
        tick(1'b0, '0, 1'b0);
        check("ovf_clear", overflow, 0);
        exp_q.push_back(8'h00);
        tick(1'b1, 8'hEE, 1'b1);
        check("wf_count", count, 15);
        check("wf_ovf", overflow, 1);
        check("wf_full", full, 0);
        for (int i = 1; i < DEPTH; i++) begin
            rd_exp(8'(i));
            exp_cnt = 15 - i;
            check("d_count", count, exp_cnt);
            check("d_ae", almost_empty, (exp_cnt <= 4) ? 1 : 0);
        end
        check("d_empty", empty, 1);
        tick(1'b0, '0, 1'b0);

        // Steady state at count 8 with simultaneous read/write
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h40 + i), 1'b0);
        check("s_count8", count, 8);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(8'h40 + i));
            tick(1'b1, 8'(8'h48 + i), 1'b1);
            check("s_count", count, 8);
        end
        for (int i = 0; i < 8; i++) rd_exp(8'(8'h68 + i));
        check("s_empty", empty, 1);
        tick(1'b0, '0, 1'b0);
`else
        // First-word-fall-through: word visible without rd_en
        tick(1'b1, 8'hA5, 1'b0);
        check("fw_valid1", out_valid, 1);
        check("fw_data", fifo_out, 8'hA5);
        tick(1'b0, '0, 1'b0);
        check("fw_hold", out_valid, 1);
        rd_exp(8'hA5);
        check("fw_valid0", out_valid, 0);
        check("fw_empty", empty, 1);
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        rd_exp(8'h01);
        rd_exp(8'h02);
        check("fw_count0", count, 0);
`endif

        // Asynchronous reset mid-cycle with 5 entries stored
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h90 + i), 1'b0);
        check("ar_count5", count, 5);
        #2;
        rst = 1'b1;
        #1;
        check("ar_empty", empty, 1);
        check("ar_count", count, 0);
        check("ar_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1, 8'h5A, 1'b0);
        check("ar_after", count, 1);
        rd_exp(8'h5A);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);

        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
